// File: rtl/keyboard_pkg.sv
// Shared types and constants for the keyboard synthesizer datapath.
package keyboard_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        RECV   = 2'd1,
        CHECK  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        WAVE_SQUARE = 2'd0,
        WAVE_SAW    = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_SINE   = 2'd3
    } wave_t;

    localparam int unsigned WORD_W            = 32;
    localparam logic [31:0] DEFAULT_SYNC_WORD = 32'h0000_FFFF;
    // Generators divide the period by 32, so anything shorter is unplayable.
    localparam int unsigned MIN_PERIOD        = 32;

endpackage

// File: rtl/sck_sync.sv
// Brings the asynchronous SPI sck/sdi lines into the clk domain and flags sck rising edges.
module sck_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sck,
    input  logic sdi,
    output logic rise,
    output logic sdi_s
);

    logic [SYNC_STAGES-1:0] sck_q;
    logic [SYNC_STAGES-1:0] sdi_q;
    logic                   sck_prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sck_q      <= '0;
            sdi_q      <= '0;
            sck_prev_q <= 1'b0;
        end else begin
            sck_q      <= {sck_q[SYNC_STAGES-2:0], sck};
            sdi_q      <= {sdi_q[SYNC_STAGES-2:0], sdi};
            sck_prev_q <= sck_q[SYNC_STAGES-1];
        end
    end

    assign rise  = sck_q[SYNC_STAGES-1] & ~sck_prev_q;
    assign sdi_s = sdi_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_frame_decoder.sv
// Hunts for the sync word on the SPI stream and publishes three note periods plus
// waveform/note-count fields atomically once a complete, sane frame has arrived.
module spi_frame_decoder
    import keyboard_pkg::*;
#(
    parameter logic [31:0] SYNC_WORD   = DEFAULT_SYNC_WORD,
    parameter int unsigned TIMEOUT_CYC = 4000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sck,
    input  logic        sdi,
    output logic [31:0] prd1,
    output logic [31:0] prd2,
    output logic [31:0] prd3,
    output logic [1:0]  waveform,
    output logic [1:0]  notes,
    output logic        frame_valid,
    output logic        frame_err
);

    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYC + 1);

    state_t              state_q, state_d;
    logic                rise, sdi_s;
    logic [WORD_W-1:0]   shift_q;
    logic [WORD_W-1:0]   shift_next_c;
    logic [4:0]          bit_cnt_q;
    logic [1:0]          word_idx_q;
    logic [IDLE_W-1:0]   idle_cnt_q;
    logic [WORD_W-1:0]   stage_q [4];
    logic                sync_pend_q;
    logic                sync_hit_c;
    logic                frame_ok_c;
    logic                commit_c;
    logic                err_c;
    logic [1:0]          notes_c;

    sck_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sck_sync (
        .clk   (clk),
        .reset (reset),
        .sck   (sck),
        .sdi   (sdi),
        .rise  (rise),
        .sdi_s (sdi_s)
    );

    assign shift_next_c = {shift_q[WORD_W-2:0], sdi_s};
    assign sync_hit_c   = rise && (shift_next_c == SYNC_WORD);
    assign notes_c      = stage_q[3][3:2];

    // Only the periods the frame actually plays must be long enough.
    assign frame_ok_c = (notes_c != 2'd0)
                     && (stage_q[0] >= WORD_W'(MIN_PERIOD))
                     && ((notes_c < 2'd2) || (stage_q[1] >= WORD_W'(MIN_PERIOD)))
                     && ((notes_c < 2'd3) || (stage_q[2] >= WORD_W'(MIN_PERIOD)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        commit_c = 1'b0;
        err_c    = 1'b0;
        case (state_q)
            HUNT: begin
                if (sync_hit_c || sync_pend_q) begin
                    state_d = RECV;
                end
            end
            RECV: begin
                if (rise) begin
                    if ((bit_cnt_q == 5'd31) && (word_idx_q == 2'd3)) begin
                        state_d = CHECK;
                    end
                end else if (idle_cnt_q == IDLE_W'(TIMEOUT_CYC)) begin
                    err_c   = 1'b1;
                    state_d = HUNT;
                end
            end
            CHECK: begin
                if (frame_ok_c) begin
                    commit_c = 1'b1;
                    state_d  = COMMIT;
                end else begin
                    err_c   = 1'b1;
                    state_d = HUNT;
                end
            end
            COMMIT: begin
                state_d = HUNT;
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            word_idx_q  <= '0;
            idle_cnt_q  <= '0;
            sync_pend_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                stage_q[i] <= '0;
            end
            prd1        <= '0;
            prd2        <= '0;
            prd3        <= '0;
            waveform    <= '0;
            notes       <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= commit_c;
            frame_err   <= err_c;

            if (rise) begin
                shift_q <= shift_next_c;
            end

            // A sync completing while the previous frame is being judged starts the next one.
            if (state_q == HUNT) begin
                sync_pend_q <= 1'b0;
            end else if (sync_hit_c && ((state_q == CHECK) || (state_q == COMMIT))) begin
                sync_pend_q <= 1'b1;
            end

            if (state_q == HUNT) begin
                bit_cnt_q  <= '0;
                word_idx_q <= '0;
            end else if ((state_q == RECV) && rise) begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
                if (bit_cnt_q == 5'd31) begin
                    stage_q[word_idx_q] <= shift_next_c;
                    word_idx_q          <= word_idx_q + 2'd1;
                end
            end

            if ((state_q != RECV) || rise) begin
                idle_cnt_q <= '0;
            end else if (idle_cnt_q != IDLE_W'(TIMEOUT_CYC)) begin
                idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
            end

            if (err_c) begin
                for (int i = 0; i < 4; i++) begin
                    stage_q[i] <= '0;
                end
            end

            if (commit_c) begin
                prd1     <= stage_q[0];
                prd2     <= stage_q[1];
                prd3     <= stage_q[2];
                waveform <= stage_q[3][1:0];
                notes    <= notes_c;
            end
        end
    end

endmodule

// File: tb/tb_spi_frame_decoder.sv
// Directed bench for spi_frame_decoder: bit-bangs SPI frames and checks published fields and pulses.
module tb_spi_frame_decoder;

    localparam int unsigned TIMEOUT_CYC = 4000;
    localparam int unsigned HALF        = 4;
    localparam logic [31:0] SYNC        = 32'h0000_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        sck;
    logic        sdi;
    logic [31:0] prd1, prd2, prd3;
    logic [1:0]  waveform, notes;
    logic        frame_valid, frame_err;

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int valid_base;
    int err_base;

    spi_frame_decoder #(
        .SYNC_WORD   (SYNC),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sck         (sck),
        .sdi         (sdi),
        .prd1        (prd1),
        .prd2        (prd2),
        .prd3        (prd3),
        .waveform    (waveform),
        .notes       (notes),
        .frame_valid (frame_valid),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && (frame_valid || frame_err)) begin
            check("pulse_exclusive", 32'(frame_valid & frame_err), 32'd0);
            if (frame_valid) valid_cnt++;
            if (frame_err) err_cnt++;
        end
    end

    task automatic send_bit(input logic b);
        @(negedge clk);
        sdi = b;
        repeat (HALF) @(negedge clk);
        sck = 1'b1;
        repeat (HALF) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 31; i >= 0; i--) begin
            send_bit(w[i]);
        end
    endtask

    task automatic send_frame(input logic [31:0] p1, input logic [31:0] p2,
                              input logic [31:0] p3, input logic [31:0] ctrl);
        send_word(SYNC);
        send_word(p1);
        send_word(p2);
        send_word(p3);
        send_word(ctrl);
    endtask

    task automatic mark;
        valid_base = valid_cnt;
        err_base   = err_cnt;
    endtask

    task automatic expect_out(input string tag, input int dv, input int de,
                              input logic [31:0] p1, input logic [31:0] p2, input logic [31:0] p3,
                              input logic [1:0] wf, input logic [1:0] nt);
        repeat (12) @(negedge clk);
        check({tag, ".valid_pulses"}, 32'(valid_cnt - valid_base), 32'(dv));
        check({tag, ".err_pulses"}, 32'(err_cnt - err_base), 32'(de));
        check({tag, ".prd1"}, prd1, p1);
        check({tag, ".prd2"}, prd2, p2);
        check({tag, ".prd3"}, prd3, p3);
        check({tag, ".waveform"}, 32'(waveform), 32'(wf));
        check({tag, ".notes"}, 32'(notes), 32'(nt));
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".prd1"}, prd1, 32'd0);
        check({tag, ".prd2"}, prd2, 32'd0);
        check({tag, ".prd3"}, prd3, 32'd0);
        check({tag, ".waveform"}, 32'(waveform), 32'd0);
        check({tag, ".notes"}, 32'(notes), 32'd0);
        check({tag, ".frame_valid"}, 32'(frame_valid), 32'd0);
        check({tag, ".frame_err"}, 32'(frame_err), 32'd0);
    endtask

    initial begin
        logic [16:0] garbage;
        logic [31:0] w2;
        garbage = 17'b1_0110_1001_1100_0101;
        reset = 1'b1;
        sck   = 1'b0;
        sdi   = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        check_zero("reset");

        mark();
        send_frame(32'd1000, 32'd2000, 32'd3000, 32'h7);
        expect_out("basic", 1, 0, 32'd1000, 32'd2000, 32'd3000, 2'd3, 2'd1);

        mark();
        for (int i = 16; i >= 0; i--) send_bit(garbage[i]);
        send_frame(32'd1100, 32'd2200, 32'd3300, 32'hA);
        expect_out("garbage", 1, 0, 32'd1100, 32'd2200, 32'd3300, 2'd2, 2'd2);

        mark();
        send_frame(32'd700, 32'd800, 32'd900, 32'h1);
        expect_out("notes0", 0, 1, 32'd1100, 32'd2200, 32'd3300, 2'd2, 2'd2);

        // prd1 at the limit, unused prd2/prd3 below it still publish
        mark();
        send_frame(32'd32, 32'd31, 32'd5, 32'h4);
        expect_out("minper", 1, 0, 32'd32, 32'd31, 32'd5, 2'd0, 2'd1);

        mark();
        send_frame(32'd40, 32'd31, 32'd100, 32'h8);
        expect_out("short_prd2", 0, 1, 32'd32, 32'd31, 32'd5, 2'd0, 2'd1);

        mark();
        send_word(SYNC);
        send_word(32'd1000);
        for (int i = 0; i < 8; i++) send_bit(1'b1);
        repeat (TIMEOUT_CYC + 10) @(negedge clk);
        check("timeout.err_pulses", 32'(err_cnt - err_base), 32'd1);
        check("timeout.prd1_held", prd1, 32'd32);
        mark();
        send_frame(32'd4000, 32'd5000, 32'd6000, 32'hD);
        expect_out("after_timeout", 1, 0, 32'd4000, 32'd5000, 32'd6000, 2'd1, 2'd3);

        mark();
        send_frame(32'd500, 32'd510, 32'd520, 32'h6);
        send_frame(32'd600, 32'd610, 32'd620, 32'hB);
        expect_out("b2b", 2, 0, 32'd600, 32'd610, 32'd620, 2'd3, 2'd2);

        w2 = 32'd3000;
        send_word(SYNC);
        send_word(32'd111);
        send_word(32'd222);
        for (int i = 31; i >= 22; i--) send_bit(w2[i]);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_zero("midreset");
        reset = 1'b0;
        sdi   = 1'b0;
        mark();
        send_frame(32'd1234, 32'd2345, 32'd3456, 32'hE);
        expect_out("post_reset", 1, 0, 32'd1234, 32'd2345, 32'd3456, 2'd2, 2'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
